// File: rtl/arith_enc_pkg.sv
// Shared constants, FSM encoding and helpers for the arithmetic encoder core.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arith_enc_pkg;

    localparam int          PREC          = 32;
    localparam int          FREQ_BITS     = 16;
    localparam logic [31:0] HALF          = 32'h8000_0000;
    localparam logic [31:0] QUARTER       = 32'h4000_0000;
    localparam logic [31:0] THREE_QUARTER = 32'hC000_0000;
    localparam logic [15:0] PEND_MAX      = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_UPDATE = 3'd2,
        ST_RENORM = 3'd3,
        ST_EMIT   = 3'd4,
        ST_FLUSH  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Saturating increment of the pending (follow) bit counter.
    function automatic logic [15:0] pend_inc(input logic [15:0] p);
        return (p == PEND_MAX) ? p : p + 16'd1;
    endfunction

endpackage

// File: rtl/arith_enc_bit_emit.sv
// Bit emitter: presents one coded bit followed by count_in copies of its complement.
// Latency: bit_valid rises the cycle after start; one bit per accepted handshake.
// Backpressure: bit_out/bit_valid held stable while bit_ready=0; idle low until the last bit transfers.
module arith_enc_bit_emit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        bit_in,
    input  logic [15:0] count_in,
    input  logic        bit_ready,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        idle
);

    logic [15:0] remaining;
    logic        follow;

    assign idle = ~bit_valid;

    // Load a new burst when idle, advance one bit per handshake, stall otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            remaining <= 16'd0;
            follow    <= 1'b0;
        end else if (bit_valid) begin
            if (bit_ready) begin
                if (remaining == 16'd0) begin
                    bit_valid <= 1'b0;
                    bit_out   <= 1'b0;
                end else begin
                    bit_out   <= follow;
                    remaining <= remaining - 16'd1;
                end
            end
        end else if (start) begin
            bit_out   <= bit_in;
            follow    <= ~bit_in;
            remaining <= count_in;
            bit_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/arith_enc_core.sv
// Binary arithmetic encoder core: pops symbol bounds, narrows [low,high], renormalises and emits bits.
// Latency: pop->WAIT->UPDATE->RENORM, one renorm test per cycle, emission paced by the bit handshake.
// Backpressure: FSM parks in EMIT until the emitter drains; ARITH_ENC_STATS_EN adds sym_count/bit_count.
module arith_enc_core #(
    parameter int PREC = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] upper_bound_in,
    input  logic [15:0] lower_bound_in,
    input  logic        bounds_valid_in,
    output logic        bounds_rd_en,
    input  logic        flush_in,
    output logic        bit_out,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        done_out,
    output logic        err_out,
    output logic        busy
`ifdef ARITH_ENC_STATS_EN
    ,
    output logic [31:0] sym_count,
    output logic [31:0] bit_count
`endif
);

    import arith_enc_pkg::*;

    state_t           state;
    logic             run;
    logic [PREC-1:0]  low;
    logic [PREC-1:0]  high;
    logic [15:0]      pending;
    logic [15:0]      upper_q;
    logic [15:0]      lower_q;
    logic             err;
    logic             flushing;

    logic [16:0]      u_ext;
    logic [16:0]      l_ext;
    logic             bad_sym;
    logic [PREC:0]    range;
    logic [48:0]      prod_u;
    logic [48:0]      prod_l;
    logic [PREC-1:0]  new_high;
    logic [PREC-1:0]  new_low;

    logic             case_lo;
    logic             case_hi;
    logic             case_mid;
    logic [PREC-1:0]  low_adj;
    logic [PREC-1:0]  high_adj;

    logic             emit_start;
    logic             emit_bit;
    logic [15:0]      emit_count;
    logic             emit_idle;

    // run keeps the first pop at least one cycle clear of reset release.
    assign bounds_rd_en = run && (state == ST_FETCH) && !flush_in;
    assign busy         = (state == ST_UPDATE) || (state == ST_RENORM) ||
                          (state == ST_EMIT)   || (state == ST_FLUSH);
    assign done_out     = (state == ST_DONE);
    assign err_out      = err;

    // Interval narrowing: an upper bound of 0 stands for 65536; products are 49 bits.
    always_comb begin
        u_ext    = (upper_q == 16'd0) ? 17'h1_0000 : {1'b0, upper_q};
        l_ext    = {1'b0, lower_q};
        bad_sym  = (l_ext >= u_ext);
        range    = {1'b0, high} - {1'b0, low} + (PREC+1)'(1);
        prod_u   = {16'd0, range} * {32'd0, u_ext};
        prod_l   = {16'd0, range} * {32'd0, l_ext};
        new_high = low + PREC'(prod_u >> FREQ_BITS) - PREC'(1);
        new_low  = low + PREC'(prod_l >> FREQ_BITS);
    end

    // Renormalisation case selection (priority lo, hi, mid) and pre-shift adjustment.
    always_comb begin
        case_lo  = (high < HALF);
        case_hi  = (low >= HALF);
        case_mid = (low >= QUARTER) && (high < THREE_QUARTER);
        low_adj  = low;
        high_adj = high;
        if (!case_lo && case_hi) begin
            low_adj  = low - HALF;
            high_adj = high - HALF;
        end else if (!case_lo && case_mid) begin
            low_adj  = low - QUARTER;
            high_adj = high - QUARTER;
        end
    end

    // Emitter kick: known bits from RENORM, final disambiguating bit from FLUSH.
    always_comb begin
        emit_start = 1'b0;
        emit_bit   = 1'b0;
        emit_count = pending;
        if (state == ST_RENORM && (case_lo || case_hi)) begin
            emit_start = 1'b1;
            emit_bit   = ~case_lo;
        end else if (state == ST_FLUSH) begin
            emit_start = 1'b1;
            emit_bit   = (low >= QUARTER);
            emit_count = pend_inc(pending);
        end
    end

    // Main FSM and coder state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            run      <= 1'b0;
            low      <= '0;
            high     <= '1;
            pending  <= 16'd0;
            upper_q  <= 16'd0;
            lower_q  <= 16'd0;
            err      <= 1'b0;
            flushing <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                ST_FETCH: begin
                    if (run) begin
                        state <= flush_in ? ST_FLUSH : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bounds_valid_in) begin
                        upper_q <= upper_bound_in;
                        lower_q <= lower_bound_in;
                        state   <= ST_UPDATE;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_UPDATE: begin
                    if (bad_sym) begin
                        err   <= 1'b1;
                        state <= ST_FETCH;
                    end else begin
                        high  <= new_high;
                        low   <= new_low;
                        state <= ST_RENORM;
                    end
                end
                ST_RENORM: begin
                    if (case_lo || case_hi || case_mid) begin
                        low  <= {low_adj[PREC-2:0], 1'b0};
                        high <= {high_adj[PREC-2:0], 1'b1};
                        if (case_lo || case_hi) begin
                            pending <= 16'd0;
                            state   <= ST_EMIT;
                        end else begin
                            if (pending == PEND_MAX) err <= 1'b1;
                            pending <= pend_inc(pending);
                        end
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_EMIT: begin
                    if (emit_idle) begin
                        state <= flushing ? ST_DONE : ST_RENORM;
                    end
                end
                ST_FLUSH: begin
                    if (pending == PEND_MAX) err <= 1'b1;
                    pending  <= 16'd0;
                    flushing <= 1'b1;
                    state    <= ST_EMIT;
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef ARITH_ENC_STATS_EN
    // Free-running, wrapping symbol and bit counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sym_count <= 32'd0;
            bit_count <= 32'd0;
        end else begin
            if (state == ST_UPDATE && !bad_sym) sym_count <= sym_count + 32'd1;
            if (bit_valid && bit_ready)         bit_count <= bit_count + 32'd1;
        end
    end
`endif

    arith_enc_bit_emit u_emit (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (emit_start),
        .bit_in    (emit_bit),
        .count_in  (emit_count),
        .bit_ready (bit_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .idle      (emit_idle)
    );

endmodule

// File: tb/tb_arith_enc_core.sv
// Self-checking bench for arith_enc_core: table of symbol sequences with hand-computed bit streams.
// Latency: bounds served one cycle after each pop; outputs sampled on the falling edge.
// Backpressure: bit_ready held high, toggled, or held low depending on the test.
module tb_arith_enc_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] upper_bound_in;
    logic [15:0] lower_bound_in;
    logic        bounds_valid_in;
    logic        bounds_rd_en;
    logic        flush_in;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready;
    logic        done_out;
    logic        err_out;
    logic        busy;
`ifdef ARITH_ENC_STATS_EN
    logic [31:0] sym_count;
    logic [31:0] bit_count;
`endif

    always #5 clk = ~clk;

    arith_enc_core #(.PREC(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .upper_bound_in  (upper_bound_in),
        .lower_bound_in  (lower_bound_in),
        .bounds_valid_in (bounds_valid_in),
        .bounds_rd_en    (bounds_rd_en),
        .flush_in        (flush_in),
        .bit_out         (bit_out),
        .bit_valid       (bit_valid),
        .bit_ready       (bit_ready),
        .done_out        (done_out),
        .err_out         (err_out),
        .busy            (busy)
`ifdef ARITH_ENC_STATS_EN
        ,
        .sym_count       (sym_count),
        .bit_count       (bit_count)
`endif
    );

    typedef struct {
        logic [15:0] l0, u0, l1, u1;
        int          nsym;
        int          rdy;
        int          nbits;
        logic [7:0]  bits;
        logic        err;
    } vec_t;

    vec_t        vt[10];
    logic [31:0] src_q[$];
    logic        rx_q[$];
    int          rdy_mode = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Bounds source: answers a pop one cycle later with the next queued {lower,upper}.
    initial begin : bounds_src
        logic r;
        upper_bound_in  = 16'd0;
        lower_bound_in  = 16'd0;
        bounds_valid_in = 1'b0;
        forever begin
            @(negedge clk);
            r = bounds_rd_en;
            @(posedge clk);
            #1;
            if (r === 1'b1 && rst_n === 1'b1 && src_q.size() > 0) begin
                {lower_bound_in, upper_bound_in} = src_q.pop_front();
                bounds_valid_in = 1'b1;
            end else begin
                bounds_valid_in = 1'b0;
            end
        end
    end

    // Ready driver: 0 = always ready, 1 = toggling, 2 = stalled.
    initial begin : rdy_drv
        bit_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bit_ready = ~bit_ready;
                2:       bit_ready = 1'b0;
                default: bit_ready = 1'b1;
            endcase
        end
    end

    // Bit sink: records every accepted bit.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bit_valid === 1'b1 && bit_ready === 1'b1) rx_q.push_back(bit_out);
    end

    task automatic do_reset(input string tag);
        rst_n    = 1'b0;
        flush_in = 1'b0;
        src_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rx_q.delete();
        check({tag, "_reset_outs"},
              {26'd0, bounds_rd_en, bit_out, bit_valid, done_out, err_out, busy}, 32'd0);
        rst_n = 1'b1;
    endtask

    // Wait for all queued symbols to be consumed and the FSM to return to FETCH.
    task automatic wait_idle(output logic ok);
        int cyc = 0;
        ok = 1'b0;
        while (src_q.size() != 0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        while (!ok && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (bounds_rd_en === 1'b1) ok = 1'b1;
        end
    endtask

    initial begin
        logic       ok;
        logic [7:0] w;
        logic [5:0] exp_rd;
        int         cyc;

        rst_n    = 1'b0;
        flush_in = 1'b0;

        //            l0        u0        l1        u1     nsym rdy nbits bits   err
        vt[0] = '{16'h0000, 16'h8000, 16'h0000, 16'h0000, 1, 0, 3, 8'h04, 1'b0};
        vt[1] = '{16'h4000, 16'hC000, 16'h0000, 16'h0000, 1, 0, 3, 8'h06, 1'b0};
        vt[2] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 3, 8'h05, 1'b0};
        vt[3] = '{16'h9000, 16'h9000, 16'h0000, 16'h8000, 2, 0, 3, 8'h04, 1'b1};
        vt[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 2, 8'h02, 1'b0};
        vt[5] = '{16'h0000, 16'h8000, 16'h0000, 16'h8000, 2, 1, 4, 8'h08, 1'b0};
        vt[6] = '{16'h4000, 16'hC000, 16'h4000, 16'hC000, 2, 1, 4, 8'h0E, 1'b0};
        vt[7] = '{16'h8000, 16'h0000, 16'h4000, 16'hC000, 2, 1, 4, 8'h0D, 1'b0};
        vt[8] = '{16'h4000, 16'hC000, 16'h0000, 16'h8000, 2, 1, 4, 8'h0A, 1'b0};
        vt[9] = '{16'h2000, 16'h6000, 16'h0000, 16'h0000, 1, 1, 4, 8'h0C, 1'b0};

        for (int i = 0; i < 10; i++) begin
            rdy_mode = vt[i].rdy;
            do_reset($sformatf("v%0d", i));
            if (vt[i].nsym >= 1) src_q.push_back({vt[i].l0, vt[i].u0});
            if (vt[i].nsym >= 2) src_q.push_back({vt[i].l1, vt[i].u1});
            wait_idle(ok);
            check($sformatf("v%0d_idle", i), {31'd0, ok}, 32'd1);
            @(posedge clk);
            #1 flush_in = 1'b1;
            cyc = 0;
            while (done_out !== 1'b1 && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            @(negedge clk);
            check($sformatf("v%0d_done", i), {31'd0, done_out}, 32'd1);
            check($sformatf("v%0d_nbits", i), rx_q.size(), vt[i].nbits);
            w = 8'd0;
            for (int j = 0; j < rx_q.size() && j < 8; j++) w[j] = rx_q[j];
            check($sformatf("v%0d_bits", i), {24'd0, w}, {24'd0, vt[i].bits});
            check($sformatf("v%0d_err", i), {31'd0, err_out}, {31'd0, vt[i].err});
            check($sformatf("v%0d_done_nopop", i), {30'd0, bounds_rd_en, busy}, 32'd0);
        end

        // Empty bounds source: pops alternate, first one a cycle after release.
        rdy_mode = 0;
        do_reset("alt");
        exp_rd = 6'b101010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("alt_rd_en_%0d", k), {31'd0, bounds_rd_en}, {31'd0, exp_rd[k]});
        end

        // Stall during EMIT, then reset mid-emission.
        rdy_mode = 2;
        do_reset("stall");
        src_q.push_back({16'h0000, 16'h8000});
        cyc = 0;
        while (bit_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("stall_valid_seen", {31'd0, bit_valid}, 32'd1);
        check("stall_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("stall_hold_%0d", k), {30'd0, bit_valid, bit_out}, 32'd2);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("stall_reset_outs",
              {26'd0, bounds_rd_en, bit_out, bit_valid, done_out, err_out, busy}, 32'd0);
        check("stall_no_xfer", rx_q.size(), 32'd0);
        rst_n    = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        check("stall_post_rd0", {30'd0, bounds_rd_en, bit_valid}, 32'd0);
        @(negedge clk);
        check("stall_post_fetch", {30'd0, bounds_rd_en, busy}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/arith_enc_core.md
ARITH_ENC_CORE -- requirements
Module: arith_enc_core

Interface
REQ-001 SHALL have parameter PREC, default 32, meaning low/high register width; only 32 is supported.
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous and active-low; one clock domain.
REQ-003 SHALL have ports: upper_bound_in  in  16  symbol interval top, units 2^-16, 0 means 65536; lower_bound_in  in  16  interval bottom.
REQ-004 SHALL have ports: bounds_valid_in  in  1  bounds valid, one cycle after a read; bounds_rd_en  out  1  bounds FIFO pop.
REQ-005 SHALL have ports: flush_in  in  1  end-of-stream level; bit_out  out  1  coded bit; bit_valid  out  1; bit_ready  in  1.
REQ-006 SHALL have ports: done_out  out  1  stream finished; err_out  out  1  sticky bad-interval flag; busy  out  1  not in FETCH/WAIT/DONE.

Function
REQ-007 SHALL run FSM states FETCH, WAIT, UPDATE, RENORM, EMIT, FLUSH, DONE.
REQ-008 FETCH: if flush_in=1 go FLUSH; else assert bounds_rd_en for exactly one cycle, go WAIT.
REQ-009 WAIT: bounds_valid_in=1 latches both bounds, go UPDATE; else go FETCH (retry); never two pops in consecutive cycles.
REQ-010 UPDATE (1 cycle): U=upper (0 maps to 65536), L=lower; if L>=U set err_out, skip symbol, go FETCH.
REQ-011 UPDATE: range=high-low+1 (33 bits); high=low+((range*U)>>16)-1; low=low+((range*L)>>16); products are 49 bits wide; go RENORM.
REQ-012 RENORM, one test per cycle, HALF=2^31, QUARTER=2^30: high<HALF -> emit 0; low>=HALF -> emit 1, subtract HALF from low and high.
REQ-013 RENORM: low>=QUARTER and high<3*QUARTER -> pending+1, subtract QUARTER; after any case low=low<<1, high=(high<<1)|1; no case -> FETCH.
REQ-014 Emit a bit b: present b, then pending copies of ~b, one per accepted handshake; pending cleared; then return to RENORM.
REQ-015 A bit transfers only when bit_valid=1 and bit_ready=1; bit_out is held stable while bit_valid=1 and bit_ready=0.
REQ-016 FLUSH: pending+1; emit 0 if low<QUARTER, else emit 1, per REQ-014; then go DONE.
REQ-017 DONE: done_out=1 and bounds_rd_en=0 until reset; flush_in and bounds are ignored.
REQ-018 pending is 16 bits and saturates at 65535; saturation sets err_out.
REQ-019 Initial low=0, high=0xFFFFFFFF, pending=0.

Reset
REQ-020 rst_n=0 at a clock edge SHALL return to FETCH and reinitialise per REQ-019, mid-operation included; any in-flight bit is dropped.
REQ-021 Outputs during and after reset: bounds_rd_en=0, bit_out=0, bit_valid=0, done_out=0, err_out=0, busy=0.
REQ-022 The first bounds_rd_en SHALL occur no earlier than the first cycle after rst_n rises.

Configuration
REQ-023 Macro ARITH_ENC_STATS_EN defined: add outputs sym_count[31:0] (symbols accepted in UPDATE) and bit_count[31:0] (bits handshaken); both wrap, both reset to 0.
REQ-024 Macro ARITH_ENC_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.

Structure
REQ-025 Package arith_enc_pkg SHALL hold PREC, HALF, QUARTER, THREE_QUARTER, FREQ_BITS=16 and the FSM state enum.
REQ-026 Sub-module arith_enc_bit_emit SHALL own bit_out/bit_valid, the pending-bit replay and the handshake; the core FSM waits on its idle signal.

Verification
REQ-027 Reset, then bounds (L=0x0000,U=0x8000) followed by flush_in=1 -> bit stream 0,0,1; done_out=1.
REQ-028 Reset, then bounds (L=0x4000,U=0xC000) -> pending=1, no bit emitted; then flush -> bit stream 0,1,1.
REQ-029 Bounds (L=0x8000,U=0x0000) -> first bit 1; low=0, high=0xFFFFFFFF after RENORM.
REQ-030 bounds_valid_in held 0 for 5 cycles -> bounds_rd_en pulses alternate cycles, never two consecutive.
REQ-031 Bounds (L=0x9000,U=0x9000) -> err_out=1, no bits emitted, low/high unchanged; next valid symbol codes normally.
REQ-032 bit_ready=0 for 10 cycles during EMIT, then rst_n=0 -> bit_out stable while stalled; all outputs 0 after reset; FSM in FETCH.
